// File: rtl/l1a_readout_buf.sv
// Latency ring buffer that tags each detection word with a BCID and, on L1A,
// streams a fixed window of past words over a valid/ready link.
module l1a_readout_buf #(
  parameter int DEPTH_LOG2 = 8,
  parameter int WIN        = 5,
  parameter int TFIFO_LOG2 = 3,
  parameter int BC_MAX     = 3564
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           sl1,
  input  logic [15:0]           sl2,
  input  logic [15:0]           sl3,
  input  logic                  bcr,
  input  logic                  l1a,
  input  logic [DEPTH_LOG2-1:0] latency,
  output logic [63:0]           ro_data,
  output logic                  ro_valid,
  input  logic                  ro_ready,
  output logic                  ro_last,
  output logic                  trig_overflow,
  output logic [15:0]           trig_count
);

  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int TDEPTH = 1 << TFIFO_LOG2;
  localparam int WORD_W = 60;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } state_t;

  logic [WORD_W-1:0]     ring_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] tfifo_mem [TDEPTH];

  logic [DEPTH_LOG2-1:0] wp_q;
  logic [11:0]           bcid_q, bcid_d;
  logic [WORD_W-1:0]     rd_word_q;
  logic [TFIFO_LOG2:0]   fifo_wr_q, fifo_rd_q;
  state_t                state_q, state_d;
  logic [DEPTH_LOG2-1:0] addr_q, addr_d;
  logic [3:0]            idx_q, idx_d;
  logic                  ovf_q;
  logic [15:0]           cnt_q;

  logic fifo_empty, fifo_full, pop, push_ok;

  assign fifo_empty = (fifo_wr_q == fifo_rd_q);
  assign fifo_full  = (fifo_wr_q[TFIFO_LOG2] != fifo_rd_q[TFIFO_LOG2]) &&
                      (fifo_wr_q[TFIFO_LOG2-1:0] == fifo_rd_q[TFIFO_LOG2-1:0]);
  // A pop in the same cycle frees a slot, so a full FIFO can still take the push.
  assign push_ok    = l1a && (!fifo_full || pop);

  always_comb begin
    bcid_d = bcid_q + 12'd1;
    if (bcr || (bcid_q == 12'(BC_MAX - 1))) begin
      bcid_d = 12'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ring_mem[wp_q] <= {bcid_q, sl3, sl2, sl1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_word_q <= '0;
    end else if (state_q == FETCH) begin
      rd_word_q <= ring_mem[addr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      tfifo_mem[fifo_wr_q[TFIFO_LOG2-1:0]] <= wp_q - latency;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q      <= '0;
      bcid_q    <= '0;
      fifo_wr_q <= '0;
      fifo_rd_q <= '0;
      state_q   <= IDLE;
      addr_q    <= '0;
      idx_q     <= '0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      wp_q    <= wp_q + 1'b1;
      bcid_q  <= bcid_d;
      state_q <= state_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      if (push_ok) begin
        fifo_wr_q <= fifo_wr_q + 1'b1;
        cnt_q     <= cnt_q + 16'd1;
      end
      if (pop) begin
        fifo_rd_q <= fifo_rd_q + 1'b1;
      end
      if (l1a && !push_ok) begin
        ovf_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          addr_d  = tfifo_mem[fifo_rd_q[TFIFO_LOG2-1:0]];
          idx_d   = 4'd0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        state_d = SEND;
      end
      SEND: begin
        if (ro_ready) begin
          if (idx_q == 4'(WIN - 1)) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 4'd1;
            addr_d  = addr_q + 1'b1;
            state_d = FETCH;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ro_valid      = (state_q == SEND);
  assign ro_last       = ro_valid && (idx_q == 4'(WIN - 1));
  assign ro_data       = {idx_q, rd_word_q};
  assign trig_overflow = ovf_q;
  assign trig_count    = cnt_q;

endmodule

// File: tb/tb_l1a_readout_buf.sv
// Bench for l1a_readout_buf: a time-indexed history of captured words predicts
// each window, and a scoreboard checks every word the DUT presents.
module tb_l1a_readout_buf;

  localparam int WIN    = 5;
  localparam int LAT    = 10;
  localparam int BC_MAX = 3564;

  logic        clk = 1'b0;
  logic        rst, bcr, l1a, ro_ready;
  logic [15:0] sl1, sl2, sl3;
  logic [7:0]  latency;
  logic [63:0] ro_data;
  logic        ro_valid, ro_last, trig_overflow;
  logic [15:0] trig_count;

  l1a_readout_buf dut (
    .clk           (clk),
    .rst           (rst),
    .sl1           (sl1),
    .sl2           (sl2),
    .sl3           (sl3),
    .bcr           (bcr),
    .l1a           (l1a),
    .latency       (latency),
    .ro_data       (ro_data),
    .ro_valid      (ro_valid),
    .ro_ready      (ro_ready),
    .ro_last       (ro_last),
    .trig_overflow (trig_overflow),
    .trig_count    (trig_count)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_err    = 0;
  int          cyc      = 0;
  int          base     = 0;
  int          count_m  = 0;
  bit          ovf_m    = 1'b0;
  bit          prev_hold = 1'b0;
  bit          prev_valid = 1'b0;
  logic [63:0] prev_data;
  int          rise_cyc = -1;
  logic [59:0] hist [0:8191];
  logic [63:0] exp_q [$];
  logic [63:0] got_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, sample mid-cycle against the scoreboard, then
  // advance the reference history at the edge.
  task automatic step(input bit l1a_v, input bit bcr_v, input bit rdy_v,
                      input bit rst_v, input bit acc_v);
    rst      = rst_v;
    l1a      = l1a_v;
    bcr      = bcr_v;
    ro_ready = rdy_v;
    sl1      = cyc[15:0];
    sl2      = 16'($urandom);
    sl3      = 16'($urandom);
    #3;
    if (!rst_v) begin
      chk("trig_count", 64'(trig_count), 64'(16'(count_m)));
      chk("trig_overflow", 64'(trig_overflow), 64'(ovf_m));
      if (prev_hold) begin
        chk("hold_valid", 64'(ro_valid), 64'd1);
        chk("hold_data", ro_data, prev_data);
      end
      if (ro_valid === 1'b1) begin
        if (!prev_valid && rise_cyc < 0) rise_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("spurious_valid", 64'(ro_valid), 64'd0);
        end else begin
          chk("ro_data", ro_data, exp_q[0]);
          chk("ro_last", 64'(ro_last), 64'(exp_q[0][63:60] == 4'(WIN - 1)));
          if (rdy_v) begin
            got_q.push_back(ro_data);
            void'(exp_q.pop_front());
          end
        end
      end else begin
        chk("last_idle", 64'(ro_last), 64'd0);
      end
      prev_hold  = (ro_valid === 1'b1) && !rdy_v;
      prev_data  = ro_data;
      prev_valid = (ro_valid === 1'b1);
    end else begin
      prev_hold  = 1'b0;
      prev_valid = 1'b0;
    end
    @(posedge clk);
    if (rst_v) begin
      cyc     = 0;
      base    = 0;
      count_m = 0;
      ovf_m   = 1'b0;
      exp_q.delete();
    end else begin
      hist[cyc] = {12'((cyc - base) % BC_MAX), sl3, sl2, sl1};
      if (l1a_v) begin
        if (acc_v) begin
          count_m++;
          for (int k = 0; k < WIN; k++) exp_q.push_back({4'(k), hist[cyc - LAT + k]});
        end else begin
          ovf_m = 1'b1;
        end
      end
      if (bcr_v) base = cyc + 1;
      cyc++;
    end
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, rdy, 1'b0, 1'b0);
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() > 0 && guard < 600) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      guard++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    idle(4, 1'b1);
  endtask

  int t1, t4;
  int bc_a [5] = '{3562, 3563, 0, 1, 2};
  int bc_b [5] = '{99, 100, 0, 1, 2};

  initial begin
    rst = 1'b1; l1a = 1'b0; bcr = 1'b0; ro_ready = 1'b0;
    sl1 = '0; sl2 = '0; sl3 = '0; latency = 8'(LAT);
    @(posedge clk); #1;
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("rst_valid", 64'(ro_valid), 64'd0);
    chk("rst_last", 64'(ro_last), 64'd0);
    chk("rst_data", ro_data, 64'd0);
    chk("rst_count", 64'(trig_count), 64'd0);
    chk("rst_ovf", 64'(trig_overflow), 64'd0);

    // Basic window at wp=50
    while (cyc < 50) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    t1 = cyc; rise_cyc = -1; got_q.delete();
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    drain();
    chk("t1_latency", 64'(rise_cyc), 64'(t1 + 3));
    chk("t1_words", 64'(got_q.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      chk("t1_sl1", 64'(got_q[i][15:0]), 64'(40 + i));
      chk("t1_idx", 64'(got_q[i][63:60]), 64'(i));
    end
    chk("t1_count", 64'(trig_count), 64'd1);

    // Random backpressure across three triggers
    got_q.delete();
    for (int i = 0; i < 60; i++) begin
      bit trg;
      trg = (i == 0) || (i == 9) || (i == 21);
      step(trg, 1'b0, 1'($urandom_range(0, 1)), 1'b0, trg);
    end
    drain();
    chk("t2_words", 64'(got_q.size()), 64'd15);
    for (int i = 0; i < 15; i++) chk("t2_idx", 64'(got_q[i][63:60]), 64'(i % 5));

    // Reader stalled mid-window, then 9 back-to-back triggers
    got_q.delete();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(4, 1'b0);
    chk("t3_stuck_valid", 64'(ro_valid), 64'd1);
    chk("t3_count_pre", 64'(trig_count), 64'd5);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0, 1'b0, i < 8);
    chk("t3_overflow", 64'(trig_overflow), 64'd1);
    chk("t3_count", 64'(trig_count), 64'd13);
    drain();
    chk("t3_words", 64'(got_q.size()), 64'd45);
    chk("t3_ovf_sticky", 64'(trig_overflow), 64'd1);

    // Ring wrap: trigger at wp=3
    while (!(cyc >= 259 && (cyc % 256) == 3)) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    t4 = cyc; got_q.delete();
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    drain();
    for (int i = 0; i < 5; i++) chk("t4_addr", 64'(got_q[i][7:0]), 64'(249 + i));

    // BCID wrap and bunch-counter reset
    while (cyc < 3572) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    got_q.delete();
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    drain();
    for (int i = 0; i < 5; i++) chk("t5_bcid_wrap", 64'(got_q[i][59:48]), 64'(bc_a[i]));
    while (cyc < 3664) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    while (cyc < 3673) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    got_q.delete();
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    drain();
    for (int i = 0; i < 5; i++) chk("t5_bcid_bcr", 64'(got_q[i][59:48]), 64'(bc_b[i]));

    // Reset mid-window with two triggers pending
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(3, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t6_valid", 64'(ro_valid), 64'd0);
    chk("t6_ovf", 64'(trig_overflow), 64'd0);
    chk("t6_count", 64'(trig_count), 64'd0);
    got_q.delete();
    idle(30, 1'b1);
    chk("t6_quiet", 64'(got_q.size()), 64'd0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    drain();
    chk("t6_words", 64'(got_q.size()), 64'd5);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
